// File: rtl/ifm_chunk_compressor_pkg.sv
// Shared definitions for the IFM chunk compressor: default geometry and the
// buffer / sequencer state encodings.
package ifm_chunk_compressor_pkg;
   localparam int BUS_SIZE_DFLT       = 32;
   localparam int WR_DAT_CYC_NUM_DFLT = 4;

   typedef enum logic [1:0] {
      BUF_FREE    = 2'd0,
      BUF_FILLING = 2'd1,
      BUF_READY   = 2'd2
   } buf_state_e;

   typedef enum logic {
      FSM_FILL = 1'b0,
      FSM_PAD  = 1'b1
   } fsm_state_e;
endpackage

// File: rtl/ifm_chunk_compressor_compactor.sv
// Combinational zero-skipping compactor: builds the sparsemap and packs the
// nonzero bytes toward lane 0 through a prefix-popcount select network.
module sparse_beat_compactor
   import ifm_chunk_compressor_pkg::*;
#(
   parameter int BUS_SIZE = BUS_SIZE_DFLT
) (
   input  logic [BUS_SIZE*8-1:0] dense_i,
   output logic [BUS_SIZE-1:0]   sparsemap_o,
   output logic [BUS_SIZE*8-1:0] packed_o
);
   localparam int IDX_W = $clog2(BUS_SIZE + 1);

   logic [IDX_W-1:0] pos [BUS_SIZE];

   genvar gi;
   generate
      for (gi = 0; gi < BUS_SIZE; gi++) begin : g_map
         assign sparsemap_o[gi] = |dense_i[gi*8 +: 8];
      end
   endgenerate

   // pos[i] is the output lane input lane i lands on if it is nonzero
   always_comb begin
      logic [IDX_W-1:0] run;
      run = '0;
      for (int i = 0; i < BUS_SIZE; i++) begin
         pos[i] = run;
         run    = run + IDX_W'(sparsemap_o[i]);
      end
   end

   generate
      for (gi = 0; gi < BUS_SIZE; gi++) begin : g_out
         logic [7:0] lane;
         always_comb begin
            lane = '0;
            for (int i = gi; i < BUS_SIZE; i++) begin
               if (sparsemap_o[i] && (pos[i] == IDX_W'(gi))) begin
                  lane = lane | dense_i[i*8 +: 8];
               end
            end
         end
         assign packed_o[gi*8 +: 8] = lane;
      end
   endgenerate
endmodule

// File: rtl/ifm_chunk_compressor.sv
// Compresses dense IFM beats and writes them as chunks into two ping-pong
// buffers, tracking each buffer's FREE/FILLING/READY life cycle.
module ifm_chunk_compressor
   import ifm_chunk_compressor_pkg::*;
#(
   parameter int BUS_SIZE       = BUS_SIZE_DFLT,
   parameter int WR_DAT_CYC_NUM = WR_DAT_CYC_NUM_DFLT,
   parameter int CNT_W          = $clog2(WR_DAT_CYC_NUM)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [BUS_SIZE*8-1:0] in_data_i,
   input  logic                  in_last_i,
   input  logic [1:0]            chunk_release_i,
   output logic [BUS_SIZE-1:0]   ifm_sparsemap_o,
   output logic [BUS_SIZE*8-1:0] ifm_nonzero_data_o,
   output logic                  ifm_chunk_wr_valid_o,
   output logic [CNT_W-1:0]      ifm_chunk_wr_count_o,
   output logic                  ifm_chunk_wr_sel_o,
   output logic [1:0]            ifm_chunk_rdy_o
);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WR_DAT_CYC_NUM - 1);

   logic [BUS_SIZE-1:0]   comp_sm;
   logic [BUS_SIZE*8-1:0] comp_data;

   sparse_beat_compactor #(.BUS_SIZE(BUS_SIZE)) u_compactor (
      .dense_i     (in_data_i),
      .sparsemap_o (comp_sm),
      .packed_o    (comp_data)
   );

   buf_state_e            buf_q [2];
   buf_state_e            buf_d [2];
   fsm_state_e            fsm_q, fsm_d;
   logic                  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [BUS_SIZE-1:0]   sm_q, sm_d;
   logic [BUS_SIZE*8-1:0] data_q, data_d;
   logic                  wv_q, wv_d;
   logic [CNT_W-1:0]      wcnt_q, wcnt_d;
   logic                  wsel_q, wsel_d;
   logic [1:0]            rdy_q, rdy_d;
   logic                  in_ready;
   logic                  beat_go;

   assign in_ready = (fsm_q == FSM_FILL) && (buf_q[wr_ptr_q] != BUF_READY);

   always_comb begin
      buf_d    = buf_q;
      fsm_d    = fsm_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      sm_d     = sm_q;
      data_d   = data_q;
      wv_d     = 1'b0;
      wcnt_d   = wcnt_q;
      wsel_d   = wsel_q;
      rdy_d    = '0;
      beat_go  = 1'b0;

      // Masking the release lets the flag drop the cycle after the pulse
      for (int b = 0; b < 2; b++) begin
         rdy_d[b] = (buf_q[b] == BUF_READY) && !chunk_release_i[b];
         if (chunk_release_i[b] && (buf_q[b] == BUF_READY)) begin
            buf_d[b] = BUF_FREE;
         end
      end

      if (fsm_q == FSM_PAD) begin
         beat_go = 1'b1;
         sm_d    = '0;
         data_d  = '0;
      end else if (in_valid_i && in_ready) begin
         beat_go = 1'b1;
         sm_d    = comp_sm;
         data_d  = comp_data;
      end

      if (beat_go) begin
         wv_d   = 1'b1;
         wcnt_d = cnt_q;
         wsel_d = wr_ptr_q;
         if (cnt_q == CNT_MAX) begin
            buf_d[wr_ptr_q] = BUF_READY;
            wr_ptr_d        = ~wr_ptr_q;
            cnt_d           = '0;
            fsm_d           = FSM_FILL;
         end else begin
            buf_d[wr_ptr_q] = BUF_FILLING;
            cnt_d           = cnt_q + 1'b1;
            if ((fsm_q == FSM_FILL) && in_last_i) begin
               fsm_d = FSM_PAD;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int b = 0; b < 2; b++) buf_q[b] <= BUF_FREE;
         fsm_q    <= FSM_FILL;
         wr_ptr_q <= 1'b0;
         cnt_q    <= '0;
         sm_q     <= '0;
         data_q   <= '0;
         wv_q     <= 1'b0;
         wcnt_q   <= '0;
         wsel_q   <= 1'b0;
         rdy_q    <= '0;
      end else begin
         for (int b = 0; b < 2; b++) buf_q[b] <= buf_d[b];
         fsm_q    <= fsm_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         sm_q     <= sm_d;
         data_q   <= data_d;
         wv_q     <= wv_d;
         wcnt_q   <= wcnt_d;
         wsel_q   <= wsel_d;
         rdy_q    <= rdy_d;
      end
   end

   assign in_ready_o           = in_ready;
   assign ifm_sparsemap_o      = sm_q;
   assign ifm_nonzero_data_o   = data_q;
   assign ifm_chunk_wr_valid_o = wv_q;
   assign ifm_chunk_wr_count_o = wcnt_q;
   assign ifm_chunk_wr_sel_o   = wsel_q;
   assign ifm_chunk_rdy_o      = rdy_q;
endmodule

// File: tb/tb_ifm_chunk_compressor.sv
// Bench for ifm_chunk_compressor (BUS_SIZE=4, WR_DAT_CYC_NUM=4): directed
// scenarios with literal expectations, then random traffic against a model.
module tb_ifm_chunk_compressor;
   localparam int BUS = 4;
   localparam int NB  = 4;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic [1:0]  rel;
   logic [3:0]  sm;
   logic [31:0] nz;
   logic        wv;
   logic [1:0]  wcnt;
   logic        wsel;
   logic [1:0]  rdy;

   ifm_chunk_compressor #(.BUS_SIZE(BUS), .WR_DAT_CYC_NUM(NB)) dut (
      .clk_i                (clk),
      .rst_i                (rst),
      .in_valid_i           (in_valid),
      .in_ready_o           (in_ready),
      .in_data_i            (in_data),
      .in_last_i            (in_last),
      .chunk_release_i      (rel),
      .ifm_sparsemap_o      (sm),
      .ifm_nonzero_data_o   (nz),
      .ifm_chunk_wr_valid_o (wv),
      .ifm_chunk_wr_count_o (wcnt),
      .ifm_chunk_wr_sel_o   (wsel),
      .ifm_chunk_rdy_o      (rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   bit verbose = 1'b1;

   // Model: a buffer either holds a finished chunk or it does not
   bit          m_full [2];
   bit          m_ptr;
   int          m_cnt;
   bit          m_pad;
   logic [1:0]  m_rdy;
   logic        m_wv;
   logic [1:0]  m_wcnt;
   logic        m_wsel;
   logic [3:0]  m_sm;
   logic [31:0] m_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      else n_pass++;
   endtask

   task automatic compress(input logic [31:0] d, output logic [3:0] s, output logic [31:0] p);
      int k;
      logic [7:0] byt;
      k = 0; s = '0; p = '0;
      for (int i = 0; i < BUS; i++) begin
         byt = d[8*i +: 8];
         if (byt != 8'h00) begin
            s[i] = 1'b1;
            p[8*k +: 8] = byt;
            k++;
         end
      end
   endtask

   task automatic model_step();
      logic [1:0] rdy_n;
      bit acc;
      if (rst) begin
         m_full[0] = 0; m_full[1] = 0; m_ptr = 0; m_cnt = 0; m_pad = 0;
         m_rdy = '0; m_wv = 0; m_wcnt = '0; m_wsel = 0; m_sm = '0; m_data = '0;
      end else begin
         for (int b = 0; b < 2; b++) rdy_n[b] = m_full[b] && !rel[b];
         acc = m_pad || (in_valid && !m_full[m_ptr]);
         for (int b = 0; b < 2; b++) if (rel[b]) m_full[b] = 0;
         m_wv = acc;
         if (acc) begin
            m_wcnt = 2'(m_cnt);
            m_wsel = m_ptr;
            if (m_pad) begin
               m_sm = '0; m_data = '0;
            end else begin
               compress(in_data, m_sm, m_data);
            end
            if (m_cnt == NB - 1) begin
               m_full[m_ptr] = 1; m_ptr = !m_ptr; m_cnt = 0; m_pad = 0;
            end else begin
               if (!m_pad && in_last) m_pad = 1;
               m_cnt++;
            end
         end
         m_rdy = rdy_n;
      end
   endtask

   task automatic compare_all();
      chk("in_ready",  {31'd0, in_ready}, {31'd0, !m_pad && !m_full[m_ptr]});
      chk("rdy",       {30'd0, rdy},  {30'd0, m_rdy});
      chk("wr_valid",  {31'd0, wv},   {31'd0, m_wv});
      chk("wr_count",  {30'd0, wcnt}, {30'd0, m_wcnt});
      chk("wr_sel",    {31'd0, wsel}, {31'd0, m_wsel});
      chk("sparsemap", {28'd0, sm},   {28'd0, m_sm});
      chk("data",      nz, m_data);
   endtask

   task automatic tick(input logic v, input logic [31:0] d, input logic l,
                       input logic [1:0] r, input logic rs);
      @(negedge clk);
      in_valid = v; in_data = d; in_last = l; rel = r; rst = rs;
      model_step();
      @(posedge clk);
      #1;
      compare_all();
      if (verbose && m_wv)
         $display("write sel=%0d cnt=%0d sm=%b data=%08h rdy=%b", wsel, wcnt, sm, nz, rdy);
   endtask

   function automatic logic [31:0] rand_beat();
      logic [31:0] d;
      for (int i = 0; i < BUS; i++)
         d[8*i +: 8] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      return d;
   endfunction

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; rel = '0;

      // Reset state
      tick(0, 32'h0, 0, 2'b00, 1);
      chk("rst_wv",    {31'd0, wv}, 32'd0);
      chk("rst_rdy",   {30'd0, rdy}, 32'd0);
      chk("rst_data",  nz, 32'd0);
      chk("rst_ready", {31'd0, in_ready}, 32'd1);

      // Compaction: lanes {00,05,00,07}
      tick(1, 32'h07000500, 0, 2'b00, 0);
      chk("cmp_sm",   {28'd0, sm}, 32'h0000000a);
      chk("cmp_data", nz, 32'h00000705);
      chk("cmp_cnt",  {30'd0, wcnt}, 32'd0);
      chk("cmp_sel",  {31'd0, wsel}, 32'd0);

      // Full chunk into buffer 0
      tick(1, 32'h01020304, 0, 2'b00, 0);
      tick(1, 32'h00000010, 0, 2'b00, 0);
      tick(1, 32'h80000000, 0, 2'b00, 0);
      chk("full_cnt3", {30'd0, wcnt}, 32'd3);
      tick(0, 32'h0, 0, 2'b00, 0);
      chk("full_rdy", {30'd0, rdy}, 32'h1);
      tick(1, 32'h11111111, 0, 2'b00, 0);
      chk("next_sel", {31'd0, wsel}, 32'd1);
      chk("next_cnt", {30'd0, wcnt}, 32'd0);

      // Short chunk: last on beat 1, then two pad beats
      tick(1, 32'h00220000, 1, 2'b00, 0);
      chk("short_ready", {31'd0, in_ready}, 32'd0);
      tick(0, 32'h0, 0, 2'b00, 0);
      chk("pad_cnt2", {30'd0, wcnt}, 32'd2);
      chk("pad_sm",   {28'd0, sm}, 32'd0);
      tick(0, 32'h0, 0, 2'b00, 0);
      chk("pad_cnt3", {30'd0, wcnt}, 32'd3);
      tick(0, 32'h0, 0, 2'b00, 0);
      chk("both_rdy",  {30'd0, rdy}, 32'h3);
      chk("blocked",   {31'd0, in_ready}, 32'd0);

      // Release buffer 0
      tick(0, 32'h0, 0, 2'b01, 0);
      chk("rel_rdy",   {30'd0, rdy}, 32'h2);
      chk("rel_ready", {31'd0, in_ready}, 32'd1);

      // Simultaneous release with buffer 0 filling
      tick(1, 32'h00000001, 0, 2'b00, 0);
      tick(0, 32'h0, 0, 2'b11, 0);
      chk("stray_rdy", {30'd0, rdy}, 32'h0);
      tick(1, 32'h00000002, 0, 2'b00, 0);
      tick(1, 32'h00000003, 0, 2'b00, 0);
      tick(1, 32'h00000004, 0, 2'b00, 0);
      tick(0, 32'h0, 0, 2'b00, 0);
      chk("refill_rdy", {30'd0, rdy}, 32'h1);

      // Reset mid-chunk
      tick(1, 32'h00000005, 0, 2'b00, 0);
      tick(1, 32'h00000006, 0, 2'b00, 0);
      tick(0, 32'h0, 0, 2'b00, 1);
      chk("mrst_wv",  {31'd0, wv}, 32'd0);
      chk("mrst_rdy", {30'd0, rdy}, 32'd0);
      chk("mrst_sm",  {28'd0, sm}, 32'd0);
      tick(1, 32'h00000300, 0, 2'b00, 0);
      chk("mrst_cnt", {30'd0, wcnt}, 32'd0);
      chk("mrst_sel", {31'd0, wsel}, 32'd0);
      chk("mrst_data", nz, 32'h00000003);

      // Random traffic against the model
      verbose = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         logic [1:0] r;
         r[0] = ($urandom_range(0, 4) == 0);
         r[1] = ($urandom_range(0, 4) == 0);
         tick(($urandom_range(0, 9) < 7), rand_beat(), ($urandom_range(0, 6) == 0),
              r, ($urandom_range(0, 199) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
